// File: rtl/mef_fertirrigacao_n_if.sv
// Signal bundle of the fertigation controller: zone requests, tank level sensors and actuator drives.
interface mef_fertirrigacao_n_if #(
    parameter int N_ZONES = 4
);
    logic [N_ZONES-1:0] asp;
    logic [N_ZONES-1:0] adub;
    logic               nv1;
    logic               nv0;
    logic               ve;
    logic               mist;
    logic               limp;
    logic [N_ZONES-1:0] zone_en;
    logic               busy;
    logic               fault;

    modport master (
        output asp, adub, nv1, nv0,
        input  ve, mist, limp, zone_en, busy, fault
    );

    modport slave (
        input  asp, adub, nv1, nv0,
        output ve, mist, limp, zone_en, busy, fault
    );
endinterface

// File: rtl/mef_fertirrigacao_n.sv
// Fertigation controller: fills the tank, optionally mixes fertilizer, irrigates one zone (round-robin), cleans the line.
// Optional FILL dwell timeout into FAULT is built only when FERT_FILL_TIMEOUT_EN is defined.
module mef_fertirrigacao_n #(
    parameter int N_ZONES      = 4,
    parameter int MIX_CYCLES   = 16,
    parameter int CLEAN_CYCLES = 8,
    parameter int FILL_TIMEOUT = 255,
    parameter int CNT_W        = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    mef_fertirrigacao_n_if.slave    bus
);

    localparam int SEL_W = (N_ZONES > 1) ? $clog2(N_ZONES) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FILL  = 3'd1;
    localparam logic [2:0] S_MIX   = 3'd2;
    localparam logic [2:0] S_APPLY = 3'd3;
    localparam logic [2:0] S_CLEAN = 3'd4;
    localparam logic [2:0] S_FAULT = 3'd5;

    localparam logic [CNT_W-1:0] MIX_LAST   = CNT_W'(MIX_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLEAN_LAST = CNT_W'(CLEAN_CYCLES - 1);
    localparam logic [SEL_W-1:0] LAST_RST   = SEL_W'(N_ZONES - 1);

    localparam int CNT_NEED = (MIX_CYCLES > CLEAN_CYCLES)
                            ? ((MIX_CYCLES > FILL_TIMEOUT) ? MIX_CYCLES : FILL_TIMEOUT)
                            : ((CLEAN_CYCLES > FILL_TIMEOUT) ? CLEAN_CYCLES : FILL_TIMEOUT);

    // The shared counter must be able to reach the longest dwell.
    if (CNT_NEED > (1 << CNT_W) - 1) begin : g_cnt_w_too_small
        $error("CNT_W too small for MIX_CYCLES/CLEAN_CYCLES/FILL_TIMEOUT");
    end

`ifdef FERT_FILL_TIMEOUT_EN
    localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(FILL_TIMEOUT - 1);
`endif

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] last_q, last_d;
    logic             fert_q, fert_d;
    logic [SEL_W-1:0] pick_s;
    logic             sensor_err_s;

    function automatic logic [SEL_W-1:0] rr_idx(input logic [SEL_W-1:0] last, input int off);
        int z;
        z = (int'(last) + 1 + off) % N_ZONES;
        return SEL_W'(z);
    endfunction

    assign sensor_err_s = bus.nv1 & ~bus.nv0;

    // Round-robin pick: scanning offsets downwards leaves the nearest requester after last served.
    always_comb begin
        pick_s = '0;
        for (int i = N_ZONES - 1; i >= 0; i--) begin
            pick_s = bus.asp[rr_idx(last_q, i)] ? rr_idx(last_q, i) : pick_s;
        end
    end

    // Next-state, counter and latch logic; the counter restarts at zero on every state change.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        sel_d   = sel_q;
        fert_d  = fert_q;
        last_d  = last_q;
        if ((state_q != S_FAULT) && sensor_err_s) begin
            state_d = S_FAULT;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (|bus.asp) begin
                        sel_d  = pick_s;
                        fert_d = bus.adub[pick_s];
                        if (!bus.nv1) begin
                            state_d = S_FILL;
                        end else if (bus.adub[pick_s]) begin
                            state_d = S_MIX;
                        end else begin
                            state_d = S_APPLY;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_FILL: begin
                    if (bus.nv1) begin
                        state_d = fert_q ? S_MIX : S_APPLY;
                    end else begin
`ifdef FERT_FILL_TIMEOUT_EN
                        if (cnt_q == FILL_LAST) begin
                            state_d = S_FAULT;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
`else
                        state_d = S_FILL;
`endif
                    end
                end
                S_MIX: begin
                    if (cnt_q == MIX_LAST) begin
                        state_d = S_APPLY;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_APPLY: begin
                    if (!bus.asp[sel_q]) begin
                        last_d  = sel_q;
                        state_d = fert_q ? S_CLEAN : S_IDLE;
                    end else if (!bus.nv0) begin
                        state_d = S_FILL;
                    end else begin
                        state_d = S_APPLY;
                    end
                end
                S_CLEAN: begin
                    if (cnt_q == CLEAN_LAST) begin
                        last_d  = sel_q;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_FAULT: begin
                    state_d = S_FAULT;
                end
                default: begin
                    state_d = S_FAULT;
                end
            endcase
        end
    end

    // State and latch registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sel_q   <= '0;
            fert_q  <= 1'b0;
            last_q  <= LAST_RST;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            fert_q  <= fert_d;
            last_q  <= last_d;
        end
    end

    // Moore outputs straight from the registers, so reset clears them without a clock edge.
    always_comb begin
        bus.ve      = (state_q == S_FILL);
        bus.mist    = (state_q == S_MIX);
        bus.limp    = (state_q == S_CLEAN);
        bus.zone_en = (state_q == S_APPLY) ? (N_ZONES'(1) << sel_q) : '0;
        bus.busy    = (state_q != S_IDLE) && (state_q != S_FAULT);
        bus.fault   = (state_q == S_FAULT);
    end

endmodule

// File: tb/tb_mef_fertirrigacao_n.sv
// Bench for mef_fertirrigacao_n: directed scenarios plus random serves checked against a transaction-level model.
module tb_mef_fertirrigacao_n;

    localparam int NZ = 4;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    int   last_m;

    mef_fertirrigacao_n_if #(.N_ZONES(NZ)) bus ();

    mef_fertirrigacao_n #(
        .N_ZONES(NZ), .MIX_CYCLES(4), .CLEAN_CYCLES(3), .FILL_TIMEOUT(10), .CNT_W(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] out_vec();
        return {23'd0, bus.ve, bus.mist, bus.limp, bus.busy, bus.fault, bus.zone_en};
    endfunction

    // Zone that round-robin should serve: smallest forward distance from last served.
    function automatic int rr_pick(input logic [3:0] req, input int last);
        int best;
        int bestd;
        int d;
        best  = -1;
        bestd = 99;
        for (int z = 0; z < NZ; z++) begin
            if (req[z]) begin
                d = (z - last - 1 + 8) % NZ;
                if (d < bestd) begin
                    bestd = d;
                    best  = z;
                end
            end
        end
        return best;
    endfunction

    task automatic wait_apply(output int mist_n, output int ve_n);
        mist_n = 0;
        ve_n   = 0;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (bus.mist) mist_n++;
            if (bus.ve) ve_n++;
            if (bus.zone_en != 4'd0 || bus.fault) break;
        end
        check("apply_reached", {31'd0, bus.zone_en != 4'd0}, 32'd1);
    endtask

    task automatic finish_apply(output int limp_n);
        limp_n = 0;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (bus.limp) limp_n++;
            if (!bus.busy) break;
        end
        check("back_idle", out_vec(), 32'd0);
    endtask

    task automatic serve(input logic [3:0] asp_v, input logic [3:0] adub_v);
        int   exp_z;
        logic exp_f;
        int   m;
        int   v;
        int   l;
        exp_z    = rr_pick(asp_v, last_m);
        exp_f    = adub_v[exp_z];
        bus.asp  = asp_v;
        bus.adub = adub_v;
        wait_apply(m, v);
        check("serve_zone", {28'd0, bus.zone_en}, 32'd1 << exp_z);
        check("serve_mist_cycles", m, exp_f ? 32'd4 : 32'd0);
        check("serve_no_fill", v, 32'd0);
        bus.adub = ~adub_v;
        bus.asp  = asp_v | 4'($urandom);
        repeat ($urandom_range(1, 3)) tick();
        check("serve_zone_held", {28'd0, bus.zone_en}, 32'd1 << exp_z);
        bus.asp = 4'd0;
        finish_apply(l);
        check("serve_limp_cycles", l, exp_f ? 32'd3 : 32'd0);
        last_m = exp_z;
    endtask

    initial begin
        int m;
        int v;
        int l;
        int ez;
        n_tests  = 0;
        n_fail   = 0;
        last_m   = NZ - 1;
        reset    = 1'b1;
        bus.asp  = 4'd0;
        bus.adub = 4'd0;
        bus.nv1  = 1'b1;
        bus.nv0  = 1'b1;
        #1;
        check("reset_outputs", out_vec(), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        check("idle_after_reset", out_vec(), 32'd0);

        // Fertilized zone 2 with full tank: mix, apply, clean.
        serve(4'b0100, 4'b0100);

        // Empty tank: fill until nv1, then plain irrigation.
        bus.nv1  = 1'b0;
        bus.asp  = 4'b0001;
        bus.adub = 4'b0000;
        tick();
        check("fill_ve", bus.ve, 32'd1);
        check("fill_busy", bus.busy, 32'd1);
        repeat (5) tick();
        check("fill_wait_ve", {31'd0, bus.ve}, 32'd1);
        check("fill_wait_zone", {28'd0, bus.zone_en}, 32'd0);
        bus.nv1 = 1'b1;
        wait_apply(m, v);
        check("fill_then_zone", {28'd0, bus.zone_en}, 32'd1);
        check("fill_no_mist", m, 32'd0);
        bus.asp = 4'd0;
        finish_apply(l);
        check("fill_no_limp", l, 32'd0);
        last_m = 0;

        // Reset mid-mix clears outputs without a clock edge.
        bus.asp  = 4'b0100;
        bus.adub = 4'b0100;
        tick();
        check("mix_before_reset", bus.mist, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_outputs", out_vec(), 32'd0);
        tick();
        reset   = 1'b0;
        bus.asp = 4'd0;
        last_m  = NZ - 1;
        tick();
        check("idle_after_async_reset", out_vec(), 32'd0);

        // All zones requesting: pulsing the served bit low rotates 0,1,2,3,0.
        bus.asp  = 4'hF;
        bus.adub = 4'h0;
        tick();
        for (int k = 0; k < 5; k++) begin
            ez = k % NZ;
            check("rr_zone", {28'd0, bus.zone_en}, 32'd1 << ez);
            bus.asp[ez] = 1'b0;
            tick();
            check("rr_idle", bus.busy, 32'd0);
            bus.asp = 4'hF;
            tick();
        end
        bus.asp = 4'd0;
        tick();
        check("rr_done", bus.busy, 32'd0);
        last_m = 1;

        // Refill during fertilized apply reruns the mixer then resumes the same zone.
        bus.asp  = 4'b1000;
        bus.adub = 4'b1000;
        wait_apply(m, v);
        check("refill_zone", {28'd0, bus.zone_en}, 32'h8);
        check("refill_first_mix", m, 32'd4);
        bus.nv0 = 1'b0;
        bus.nv1 = 1'b0;
        tick();
        check("refill_ve", bus.ve, 32'd1);
        check("refill_zone_off", {28'd0, bus.zone_en}, 32'd0);
        bus.nv1 = 1'b1;
        bus.nv0 = 1'b1;
        wait_apply(m, v);
        check("refill_second_mix", m, 32'd4);
        check("refill_resume_zone", {28'd0, bus.zone_en}, 32'h8);
        bus.asp = 4'd0;
        finish_apply(l);
        check("refill_limp", l, 32'd3);
        last_m = 3;

        // Request dropped during MIX: mix completes, apply lasts one cycle, then clean.
        bus.asp  = 4'b0100;
        bus.adub = 4'b0100;
        tick();
        check("drop_mix_start", bus.mist, 32'd1);
        bus.asp = 4'd0;
        wait_apply(m, v);
        check("drop_mix_total", m + 1, 32'd4);
        check("drop_apply_zone", {28'd0, bus.zone_en}, 32'h4);
        tick();
        check("drop_apply_one_cycle", {28'd0, bus.zone_en}, 32'd0);
        check("drop_clean_start", bus.limp, 32'd1);
        finish_apply(l);
        check("drop_clean_total", l + 1, 32'd3);
        last_m = 2;

        // Tank never fills.
        bus.asp  = 4'b0001;
        bus.adub = 4'b0000;
        bus.nv1  = 1'b0;
        tick();
        check("dwell_ve", bus.ve, 32'd1);
`ifdef FERT_FILL_TIMEOUT_EN
        repeat (9) tick();
        check("timeout_not_yet", {30'd0, bus.ve, bus.fault}, 32'd2);
        tick();
        check("timeout_fault", out_vec(), 32'h10);
        bus.nv1 = 1'b1;
        repeat (3) tick();
        check("timeout_sticky", bus.fault, 32'd1);
`else
        repeat (30) tick();
        check("dwell_no_timeout", {30'd0, bus.ve, bus.fault}, 32'd2);
        bus.nv1 = 1'b1;
        wait_apply(m, v);
        check("dwell_zone", {28'd0, bus.zone_en}, 32'd1);
`endif
        bus.asp = 4'd0;
        bus.nv1 = 1'b1;
        reset   = 1'b1;
        tick();
        reset  = 1'b0;
        last_m = NZ - 1;
        tick();
        check("idle_after_dwell", out_vec(), 32'd0);

        // Sensor inconsistency in APPLY: sticky fault until reset.
        bus.asp  = 4'b0001;
        bus.adub = 4'b0000;
        wait_apply(m, v);
        check("fault_pre_zone", {28'd0, bus.zone_en}, 32'd1);
        bus.nv0 = 1'b0;
        tick();
        check("fault_entry", out_vec(), 32'h10);
        bus.nv0 = 1'b1;
        bus.asp = 4'hF;
        repeat (5) tick();
        check("fault_sticky", out_vec(), 32'h10);
        bus.asp = 4'd0;
        reset   = 1'b1;
        #1;
        check("fault_cleared_by_reset", out_vec(), 32'd0);
        tick();
        reset  = 1'b0;
        last_m = NZ - 1;
        tick();

        // Random requests with a full tank.
        for (int t = 0; t < 20; t++) begin
            serve(4'($urandom_range(1, 15)), 4'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
